// File: rtl/rr_arbiter_4.sv
// Four-requester round-robin arbiter with registered one-hot grant and hold-limit timeout.
// Only one grant is active at a time, and there is always at least one idle cycle between grants.
module rr_arbiter_4 #(
    parameter int HOLD_MAX = 15,
    parameter int CNT_W    = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [3:0]       req,
    input  logic             release_i,
    output logic [3:0]       gnt,
    output logic [1:0]       gnt_idx,
    output logic             gnt_valid,
    output logic             timeout
);

    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(HOLD_MAX - 1);

    state_t           state, state_nxt;
    logic [1:0]       ptr, ptr_nxt;
    logic [CNT_W-1:0] hold_cnt, cnt_nxt;
    logic [1:0]       idx_nxt;
    logic [3:0]       gnt_nxt;
    logic             vld_nxt;
    logic             to_nxt;

    logic [1:0]       sel_idx;
    logic             sel_found;
    logic             withdrawn;
    logic             at_limit;
    logic             rel_ev;

    // Scan from the highest offset down so the candidate closest to ptr wins.
    always_comb begin
        logic [1:0] cand;
        sel_idx   = ptr;
        sel_found = 1'b0;
        for (int k = 3; k >= 0; k--) begin
            cand = ptr + 2'(k);
            if (req[cand]) begin
                sel_idx   = cand;
                sel_found = 1'b1;
            end
        end
    end

    assign withdrawn = ~req[gnt_idx];
    assign at_limit  = (hold_cnt == LIMIT);
    assign rel_ev    = release_i | withdrawn | at_limit;

    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        cnt_nxt   = hold_cnt;
        idx_nxt   = gnt_idx;
        gnt_nxt   = gnt;
        vld_nxt   = gnt_valid;
        to_nxt    = 1'b0;
        case (state)
            IDLE: begin
                if (sel_found) begin
                    state_nxt = BUSY;
                    idx_nxt   = sel_idx;
                    gnt_nxt   = 4'b0001 << sel_idx;
                    vld_nxt   = 1'b1;
                    cnt_nxt   = '0;
                end
            end
            BUSY: begin
                cnt_nxt = hold_cnt + 1'b1;
                if (rel_ev) begin
                    state_nxt = IDLE;
                    gnt_nxt   = 4'b0000;
                    vld_nxt   = 1'b0;
                    ptr_nxt   = gnt_idx + 2'd1;
                    cnt_nxt   = '0;
                    // An explicit release or withdrawal masks the timeout report.
                    to_nxt    = at_limit & ~release_i & ~withdrawn;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            ptr       <= 2'd0;
            hold_cnt  <= '0;
            gnt_idx   <= 2'd0;
            gnt       <= 4'b0000;
            gnt_valid <= 1'b0;
            timeout   <= 1'b0;
        end else begin
            state     <= state_nxt;
            ptr       <= ptr_nxt;
            hold_cnt  <= cnt_nxt;
            gnt_idx   <= idx_nxt;
            gnt       <= gnt_nxt;
            gnt_valid <= vld_nxt;
            timeout   <= to_nxt;
        end
    end

endmodule

// File: tb/tb_rr_arbiter_4.sv
// Scoreboard bench for rr_arbiter_4: stimulus queues expected grants, monitor checks each grant.
module tb_rr_arbiter_4;

    logic       clk;
    logic       rst_n;
    logic [3:0] req;
    logic       release_i;
    logic [3:0] gnt;
    logic [1:0] gnt_idx;
    logic       gnt_valid;
    logic       timeout;

    rr_arbiter_4 #(.HOLD_MAX(4), .CNT_W(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .release_i (release_i),
        .gnt       (gnt),
        .gnt_idx   (gnt_idx),
        .gnt_valid (gnt_valid),
        .timeout   (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // len < 0 marks a grant that reset cuts short; only its start is checked.
    typedef struct {
        logic [3:0] g;
        logic [1:0] idx;
        int         len;
        logic       to;
    } exp_t;

    exp_t q[$];
    int   n_pass = 0;
    int   n_total = 0;
    logic in_grant = 1'b0;
    int   cur_len = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [3:0] g, input logic [1:0] i, input int len, input logic to);
        exp_t e;
        e.g = g; e.idx = i; e.len = len; e.to = to;
        q.push_back(e);
    endtask

    // Grant from IDLE, hold one cycle, release explicitly, return to IDLE.
    task automatic one_shot(input logic [3:0] r);
        req = r;
        tick(1);
        release_i = 1'b1;
        tick(1);
        release_i = 1'b0;
        req = 4'b0000;
        tick(1);
    endtask

    // Monitor: sampled on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            if (in_grant && q.size() > 0) void'(q.pop_front());
            in_grant = 1'b0;
            cur_len  = 0;
        end else begin
            logic ended;
            ended = 1'b0;
            chk("gnt_decode", int'(gnt), gnt_valid ? int'(4'b0001 << gnt_idx) : 0);
            if (gnt_valid && !in_grant) begin
                if (q.size() == 0) begin
                    chk("unexpected_grant", int'(gnt), 0);
                end else begin
                    chk("grant_gnt", int'(gnt), int'(q[0].g));
                    chk("grant_idx", int'(gnt_idx), int'(q[0].idx));
                end
                in_grant = 1'b1;
                cur_len  = 1;
            end else if (gnt_valid && in_grant) begin
                cur_len++;
            end else if (!gnt_valid && in_grant) begin
                ended = 1'b1;
                if (q.size() > 0) begin
                    if (q[0].len >= 0) chk("hold_len", cur_len, q[0].len);
                    chk("timeout_at_release", int'(timeout), int'(q[0].to));
                    void'(q.pop_front());
                end
                in_grant = 1'b0;
            end
            if (!ended) chk("timeout_quiet", int'(timeout), 0);
        end
    end

    initial begin
        rst_n = 1'b0;
        req = 4'b0000;
        release_i = 1'b0;
        #12;
        chk("rst_gnt", int'(gnt), 0);
        chk("rst_idx", int'(gnt_idx), 0);
        chk("rst_valid", int'(gnt_valid), 0);
        chk("rst_timeout", int'(timeout), 0);
        rst_n = 1'b1;
        tick(1);

        // Rotation from ptr=0 with all requesting, 2-cycle holds.
        push(4'b0001, 2'd0, 2, 1'b0);
        push(4'b0010, 2'd1, 2, 1'b0);
        push(4'b0100, 2'd2, 2, 1'b0);
        push(4'b1000, 2'd3, 2, 1'b0);
        push(4'b0001, 2'd0, 2, 1'b0);
        req = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            tick(1);
            tick(1);
            release_i = 1'b1;
            tick(1);
            release_i = 1'b0;
            if (i == 4) req = 4'b0000;
        end
        tick(1);

        // Single request (ptr=1 scans to 2).
        push(4'b0100, 2'd2, 1, 1'b0);
        one_shot(4'b0100);

        // Pointer wrap: owner 3 then req=1001 must pick 0.
        push(4'b1000, 2'd3, 1, 1'b0);
        one_shot(4'b1000);
        push(4'b0001, 2'd0, 1, 1'b0);
        one_shot(4'b1001);

        // Hold limit, then release coinciding with the limit.
        push(4'b0001, 2'd0, 4, 1'b1);
        push(4'b0001, 2'd0, 4, 1'b0);
        req = 4'b0001;
        tick(1);
        tick(4);
        tick(1);
        tick(3);
        release_i = 1'b1;
        tick(1);
        release_i = 1'b0;
        req = 4'b0000;
        tick(1);

        // Withdrawal of owner 1 hands over to 2 without timeout.
        push(4'b0010, 2'd1, 1, 1'b0);
        push(4'b0100, 2'd2, 1, 1'b0);
        req = 4'b0110;
        tick(1);
        req = 4'b0100;
        tick(1);
        tick(1);
        release_i = 1'b1;
        tick(1);
        release_i = 1'b0;
        req = 4'b0000;
        tick(1);

        // Asynchronous reset while gnt=0010 (ptr=3 scans 3,0,1).
        push(4'b0010, 2'd1, -1, 1'b0);
        req = 4'b0010;
        tick(1);
        tick(1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("midrst_gnt", int'(gnt), 0);
        chk("midrst_valid", int'(gnt_valid), 0);
        chk("midrst_timeout", int'(timeout), 0);
        chk("midrst_idx", int'(gnt_idx), 0);
        req = 4'b0000;
        #10;
        rst_n = 1'b1;
        tick(1);
        push(4'b0001, 2'd0, 1, 1'b0);
        one_shot(4'b1111);

        begin
            int budget;
            budget = 50;
            while ((q.size() != 0 || in_grant) && budget > 0) begin
                tick(1);
                budget--;
            end
        end
        chk("scoreboard_drain", q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
